life_engine: RTL and testbench

Cell-state engine for the Game of Life display path, sitting directly upstream of the VGA grid generator. Holds the current generation of a GRID_W x GRID_H cell grid and computes the next generation one cell per clock using rule B3/S23. It answers per-cell display lookups from a registered read port, and publishes a new generation only at a frame boundary so the display never tears.

---
 rtl/life_pkg.sv | 16 +
 rtl/life_cell_rule.sv | 19 +
 rtl/life_engine.sv | 143 ++++++++++++++
 tb/tb_life_engine.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared types and constants for the Game of Life cell-state engine.
package life_pkg;

  localparam int unsigned COORD_W    = 8;
  localparam int unsigned GEN_W      = 16;
  localparam int unsigned BIRTH      = 3;
  localparam int unsigned SURVIVE_LO = 2;
  localparam int unsigned SURVIVE_HI = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPUTE   = 2'd1,
    WAIT_SWAP = 2'd2
  } life_state_e;

endpackage

// File: rtl/life_cell_rule.sv
// B3/S23 decision for a single cell from its eight neighbours and itself.
module life_cell_rule
  import life_pkg::*;
(
  input  logic [7:0] nbrs,
  input  logic       self_alive,
  output logic       next_alive_c
);

  logic [3:0] live_cnt;

  // Popcount the neighbourhood and apply birth/survival thresholds
  always_comb begin
    live_cnt     = 4'($countones(nbrs));
    next_alive_c = (live_cnt == 4'(BIRTH)) ||
                   (self_alive && (live_cnt >= 4'(SURVIVE_LO)) && (live_cnt <= 4'(SURVIVE_HI)));
  end

endmodule

// File: rtl/life_engine.sv
// Double-buffered Game of Life engine: one cell per clock, frame-synchronous publish.
module life_engine
  import life_pkg::*;
#(
  parameter int unsigned GRID_W = 16,
  parameter int unsigned GRID_H = 16,
  parameter bit          WRAP   = 1'b1,
  parameter logic [GRID_W*GRID_H-1:0] INIT_MAP =
      ((GRID_W*GRID_H)'(1) << 1) |
      ((GRID_W*GRID_H)'(1) << (GRID_W + 2)) |
      ((GRID_W*GRID_H)'(7) << (2 * GRID_W))
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               step_req,
  input  logic               frame_sync,
  input  logic [COORD_W-1:0] rd_x,
  input  logic [COORD_W-1:0] rd_y,
  output logic               rd_alive,
  input  logic               wr_en,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic               wr_val,
  output logic               busy,
  output logic [GEN_W-1:0]   generation
);

  localparam int unsigned NCELLS = GRID_W * GRID_H;
  localparam int unsigned IDX_W  = (NCELLS > 1) ? $clog2(NCELLS) : 1;
  localparam int unsigned LIN_W  = 2 * COORD_W;
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(GRID_H - 1);

  life_state_e         state_q, state_d;
  logic [NCELLS-1:0]   cur, nxt;
  logic [COORD_W-1:0]  scan_x, scan_y;
  logic [COORD_W-1:0]  xm, xp, ym, yp;
  logic                xm_ok, xp_ok, ym_ok, yp_ok;
  logic [7:0]          nbrs;
  logic                self_alive;
  logic                next_alive_c;
  logic                scan_last;

  // Row-major linear index of an in-grid coordinate
  function automatic logic [IDX_W-1:0] cell_idx(input logic [COORD_W-1:0] x,
                                                input logic [COORD_W-1:0] y);
    logic [LIN_W-1:0] lin;
    lin = LIN_W'(y) * LIN_W'(GRID_W) + LIN_W'(x);
    return lin[IDX_W-1:0];
  endfunction

  function automatic logic in_grid(input logic [COORD_W-1:0] x,
                                   input logic [COORD_W-1:0] y);
    return (x <= X_MAX) && (y <= Y_MAX);
  endfunction

  // Neighbour coordinates around the scan cell; edge cells either wrap or read as dead
  always_comb begin
    xm    = (scan_x == '0)    ? X_MAX : scan_x - COORD_W'(1);
    xp    = (scan_x == X_MAX) ? '0    : scan_x + COORD_W'(1);
    ym    = (scan_y == '0)    ? Y_MAX : scan_y - COORD_W'(1);
    yp    = (scan_y == Y_MAX) ? '0    : scan_y + COORD_W'(1);
    xm_ok = WRAP || (scan_x != '0);
    xp_ok = WRAP || (scan_x != X_MAX);
    ym_ok = WRAP || (scan_y != '0);
    yp_ok = WRAP || (scan_y != Y_MAX);

    nbrs[0] = xm_ok && ym_ok && cur[cell_idx(xm,     ym)];
    nbrs[1] =          ym_ok && cur[cell_idx(scan_x, ym)];
    nbrs[2] = xp_ok && ym_ok && cur[cell_idx(xp,     ym)];
    nbrs[3] = xm_ok &&          cur[cell_idx(xm,     scan_y)];
    nbrs[4] = xp_ok &&          cur[cell_idx(xp,     scan_y)];
    nbrs[5] = xm_ok && yp_ok && cur[cell_idx(xm,     yp)];
    nbrs[6] =          yp_ok && cur[cell_idx(scan_x, yp)];
    nbrs[7] = xp_ok && yp_ok && cur[cell_idx(xp,     yp)];

    self_alive = cur[cell_idx(scan_x, scan_y)];
    scan_last  = (scan_x == X_MAX) && (scan_y == Y_MAX);
  end

  life_cell_rule u_rule (
    .nbrs         (nbrs),
    .self_alive   (self_alive),
    .next_alive_c (next_alive_c)
  );

  // Next-state logic: IDLE -> COMPUTE -> WAIT_SWAP -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (step_req)   state_d = COMPUTE;
      COMPUTE:   if (scan_last)  state_d = WAIT_SWAP;
      WAIT_SWAP: if (frame_sync) state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Grid buffers, scan counter, generation count and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur        <= INIT_MAP;
      nxt        <= '0;
      scan_x     <= '0;
      scan_y     <= '0;
      generation <= '0;
      busy       <= 1'b0;
      rd_alive   <= 1'b0;
    end else begin
      busy     <= (state_d != IDLE);
      rd_alive <= in_grid(rd_x, rd_y) && cur[cell_idx(rd_x, rd_y)];
      case (state_q)
        IDLE: begin
          if (wr_en && in_grid(wr_x, wr_y)) cur[cell_idx(wr_x, wr_y)] <= wr_val;
          scan_x <= '0;
          scan_y <= '0;
        end
        COMPUTE: begin
          nxt[cell_idx(scan_x, scan_y)] <= next_alive_c;
          if (scan_x == X_MAX) begin
            scan_x <= '0;
            scan_y <= scan_y + COORD_W'(1);
          end else begin
            scan_x <= scan_x + COORD_W'(1);
          end
        end
        WAIT_SWAP: begin
          if (frame_sync) begin
            cur        <= nxt;
            generation <= generation + GEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_life_engine.sv
// Directed scoreboard bench for life_engine, toroidal and bounded instances side by side.
module tb_life_engine;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        step_req = 1'b0;
  logic        frame_sync = 1'b0;
  logic [7:0]  rd_x = '0, rd_y = '0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_x = '0, wr_y = '0;
  logic        wr_val = 1'b0;
  logic        rd_alive_w, rd_alive_n, busy_w, busy_n;
  logic [15:0] gen_w, gen_n;

  int checks = 0;
  int failures = 0;

  bit mw[16][16];
  bit mn[16][16];

  typedef struct packed { logic ew; logic en; } rd_exp_t;
  rd_exp_t exp_q[$];

  life_engine #(.GRID_W(16), .GRID_H(16), .WRAP(1'b1)) dut_w (
    .clk(clk), .reset_n(reset_n), .step_req(step_req), .frame_sync(frame_sync),
    .rd_x(rd_x), .rd_y(rd_y), .rd_alive(rd_alive_w),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_val(wr_val),
    .busy(busy_w), .generation(gen_w)
  );

  life_engine #(.GRID_W(16), .GRID_H(16), .WRAP(1'b0)) dut_n (
    .clk(clk), .reset_n(reset_n), .step_req(step_req), .frame_sync(frame_sync),
    .rd_x(rd_x), .rd_y(rd_y), .rd_alive(rd_alive_n),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_val(wr_val),
    .busy(busy_n), .generation(gen_n)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog time=%0t limit=5000000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ncount(input bit wrap, input int x, input int y);
    int n, xx, yy;
    n = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) begin
        if (dx != 0 || dy != 0) begin
          xx = x + dx;
          yy = y + dy;
          if (wrap) n += int'(mw[(yy + 16) % 16][(xx + 16) % 16]);
          else if (xx >= 0 && xx < 16 && yy >= 0 && yy < 16) n += int'(mn[yy][xx]);
        end
      end
    return n;
  endfunction

  task automatic model_step();
    bit tw[16][16];
    bit tn[16][16];
    int c;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) begin
        c = ncount(1'b1, x, y);
        tw[y][x] = (c == 3) || (mw[y][x] && c == 2);
        c = ncount(1'b0, x, y);
        tn[y][x] = (c == 3) || (mn[y][x] && c == 2);
      end
    mw = tw;
    mn = tn;
  endtask

  task automatic model_reset();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) begin
        mw[y][x] = 1'b0;
        mn[y][x] = 1'b0;
      end
    mw[0][1] = 1'b1; mw[1][2] = 1'b1; mw[2][0] = 1'b1; mw[2][1] = 1'b1; mw[2][2] = 1'b1;
    mn = mw;
  endtask

  // Drive a lookup, queue the expectation, compare one edge later
  task automatic rd_check(input int x, input int y, input bit ew, input bit en, input string tag);
    rd_exp_t e;
    rd_x = 8'(x);
    rd_y = 8'(y);
    e.ew = ew;
    e.en = en;
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    chk($sformatf("%s_wrap(%0d,%0d)", tag, x, y), 16'(rd_alive_w), 16'(e.ew));
    chk($sformatf("%s_nowrap(%0d,%0d)", tag, x, y), 16'(rd_alive_n), 16'(e.en));
  endtask

  task automatic grid_check(input string tag);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        rd_check(x, y, mw[y][x], mn[y][x], tag);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int x, input int y, input bit v);
    wr_x = 8'(x); wr_y = 8'(y); wr_val = v; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    if (x < 16 && y < 16) begin
      mw[y][x] = v;
      mn[y][x] = v;
    end
  endtask

  task automatic pulse_step();
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
  endtask

  // Full step with frame_sync placed on the first WAIT_SWAP edge
  task automatic do_step(input string tag);
    pulse_step();
    chk({tag, "_busy_rise_w"}, 16'(busy_w), 16'd1);
    tick(256);
    frame_sync = 1'b1;
    tick(1);
    frame_sync = 1'b0;
    model_step();
    chk({tag, "_busy_fall_w"}, 16'(busy_w), 16'd0);
    chk({tag, "_busy_fall_n"}, 16'(busy_n), 16'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    tick(3);
    reset_n = 1'b1;

    // Reset state
    chk("rst_busy_w", 16'(busy_w), 16'd0);
    chk("rst_busy_n", 16'(busy_n), 16'd0);
    chk("rst_gen_w", gen_w, 16'd0);
    chk("rst_gen_n", gen_n, 16'd0);
    grid_check("reset");

    // Blinker on a cleared grid, plus out-of-range edits and lookups
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        wr(x, y, 1'b0);
    wr(1, 5, 1'b1); wr(2, 5, 1'b1); wr(3, 5, 1'b1);
    wr(16, 0, 1'b1); wr(0, 16, 1'b1); wr(255, 255, 1'b1);
    grid_check("edit");
    rd_check(20, 3, 1'b0, 1'b0, "oob");
    rd_check(17, 4, 1'b0, 1'b0, "oob");
    rd_check(2, 16, 1'b0, 1'b0, "oob");
    do_step("blink1");
    chk("blink1_gen_w", gen_w, 16'd1);
    chk("blink1_gen_n", gen_n, 16'd1);
    rd_check(2, 4, 1'b1, 1'b1, "blink_v");
    rd_check(2, 5, 1'b1, 1'b1, "blink_v");
    rd_check(2, 6, 1'b1, 1'b1, "blink_v");
    rd_check(1, 5, 1'b0, 1'b0, "blink_v");
    grid_check("blink1");
    do_step("blink2");
    chk("blink2_gen_w", gen_w, 16'd2);
    rd_check(1, 5, 1'b1, 1'b1, "blink_h");
    rd_check(3, 5, 1'b1, 1'b1, "blink_h");
    rd_check(2, 4, 1'b0, 1'b0, "blink_h");
    grid_check("blink2");

    // Glider for 64 generations: back home on the torus, block in the corner otherwise
    do_reset();
    for (int i = 0; i < 64; i++) do_step($sformatf("glider%0d", i));
    chk("glider_gen_w", gen_w, 16'd64);
    chk("glider_gen_n", gen_n, 16'd64);
    rd_check(1, 0, 1'b1, 1'b0, "glider_home");
    rd_check(2, 1, 1'b1, 1'b0, "glider_home");
    rd_check(0, 2, 1'b1, 1'b0, "glider_home");
    rd_check(1, 2, 1'b1, 1'b0, "glider_home");
    rd_check(2, 2, 1'b1, 1'b0, "glider_home");
    rd_check(14, 14, 1'b0, 1'b1, "corner_block");
    rd_check(15, 14, 1'b0, 1'b1, "corner_block");
    rd_check(14, 15, 1'b0, 1'b1, "corner_block");
    rd_check(15, 15, 1'b0, 1'b1, "corner_block");
    grid_check("glider64");

    // Long wait for frame_sync; a sync on the last COMPUTE edge must not swap
    pulse_step();
    tick(255);
    frame_sync = 1'b1;
    tick(1);
    frame_sync = 1'b0;
    chk("wait_busy_w", 16'(busy_w), 16'd1);
    grid_check("wait_stale");
    tick(750);
    chk("wait_busy_late_w", 16'(busy_w), 16'd1);
    chk("wait_busy_late_n", 16'(busy_n), 16'd1);
    chk("wait_gen_w", gen_w, 16'd64);
    frame_sync = 1'b1;
    tick(1);
    frame_sync = 1'b0;
    model_step();
    chk("swap_busy_w", 16'(busy_w), 16'd0);
    chk("swap_busy_n", 16'(busy_n), 16'd0);
    chk("swap_gen_w", gen_w, 16'd65);
    chk("swap_gen_n", gen_n, 16'd65);
    grid_check("after_wait");

    // step_req and edits while busy are dropped
    pulse_step();
    tick(10);
    step_req = 1'b1; wr_x = 8'd10; wr_y = 8'd10; wr_val = 1'b1; wr_en = 1'b1;
    tick(1);
    step_req = 1'b0; wr_en = 1'b0;
    tick(245);
    step_req = 1'b1;
    frame_sync = 1'b1;
    tick(1);
    step_req = 1'b0;
    frame_sync = 1'b0;
    model_step();
    chk("busy_drop_busy_w", 16'(busy_w), 16'd0);
    tick(1);
    chk("busy_drop_noqueue_w", 16'(busy_w), 16'd0);
    chk("busy_drop_noqueue_n", 16'(busy_n), 16'd0);
    chk("busy_drop_gen_w", gen_w, 16'd66);
    chk("busy_drop_gen_n", gen_n, 16'd66);
    rd_check(10, 10, 1'b0, 1'b0, "dropped_edit");
    rd_check(20, 3, 1'b0, 1'b0, "oob");
    grid_check("busy_drop");

    // Asynchronous reset in the middle of COMPUTE
    pulse_step();
    tick(50);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_busy_w", 16'(busy_w), 16'd0);
    chk("midrst_busy_n", 16'(busy_n), 16'd0);
    chk("midrst_gen_w", gen_w, 16'd0);
    chk("midrst_gen_n", gen_n, 16'd0);
    chk("midrst_rd_w", 16'(rd_alive_w), 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    grid_check("midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
